// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
//   Sequences the SYS_CTRL output path towards the UART TX FIFO write side.
//   Arbitrates between a 1-byte register-file read (req0) and a 2-byte ALU
//   result (req1, LSB first), drives the registered output-mux select and
//   serialises the granted frame byte by byte under FIFO back-pressure.
//
//   Ports:
//     CLK, RST              clock, synchronous active-high reset
//     req0_valid/data/ack   register-file requester (1 byte)
//     req1_valid/data/ack   ALU requester (2 bytes, low byte first)
//     fifo_full             FIFO cannot accept a write this cycle
//     wr_en, wr_data        FIFO write strobe and byte
//     mux_sel               current grant (0=req0, 1=req1)
//     busy                  high whenever not idle
//
//   Build option: define TX_ARB_FIXED_PRIO_EN for fixed priority (req1 wins
//   ties); otherwise ties are resolved round-robin.
module tx_frame_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req0_valid,
  input  logic [DATA_WIDTH-1:0]   req0_data,
  output logic                    req0_ack,
  input  logic                    req1_valid,
  input  logic [2*DATA_WIDTH-1:0] req1_data,
  output logic                    req1_ack,
  input  logic                    fifo_full,
  output logic                    wr_en,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    mux_sel,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE,
    SEND0,
    SEND1_LO,
    SEND1_HI,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [2*DATA_WIDTH-1:0] frame;
  logic [DATA_WIDTH-1:0]   wr_data_last;
  logic                    grant_take;
  logic                    grant_idx;
`ifndef TX_ARB_FIXED_PRIO_EN
  logic                    last_grant;
`endif

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    wr_data    = wr_data_last;
    grant_take = 1'b0;
    grant_idx  = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_take = 1'b1;
`ifdef TX_ARB_FIXED_PRIO_EN
          grant_idx  = req1_valid;
`else
          // Tie goes to whichever requester was not served last.
          grant_idx  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
`endif
          state_nxt  = grant_idx ? SEND1_LO : SEND0;
        end
      end
      SEND0: begin
        wr_en   = !fifo_full;
        wr_data = frame[DATA_WIDTH-1:0];
        if (!fifo_full) state_nxt = DONE;
      end
      SEND1_LO: begin
        wr_en   = !fifo_full;
        wr_data = frame[DATA_WIDTH-1:0];
        if (!fifo_full) state_nxt = SEND1_HI;
      end
      SEND1_HI: begin
        wr_en   = !fifo_full;
        wr_data = frame[2*DATA_WIDTH-1:DATA_WIDTH];
        if (!fifo_full) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      mux_sel      <= 1'b0;
      frame        <= '0;
      wr_data_last <= '0;
`ifndef TX_ARB_FIXED_PRIO_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      state        <= state_nxt;
      // Outside SEND states wr_data replays the last driven byte.
      wr_data_last <= wr_data;
      if (grant_take) begin
        mux_sel <= grant_idx;
        frame   <= grant_idx ? req1_data : {{DATA_WIDTH{1'b0}}, req0_data};
`ifndef TX_ARB_FIXED_PRIO_EN
        last_grant <= grant_idx;
`endif
      end
    end
  end

  // mux_sel still holds the grant while in DONE, so it selects the ack.
  assign req0_ack = (state == DONE) && !mux_sel;
  assign req1_ack = (state == DONE) &&  mux_sel;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
module tb_tx_frame_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ack;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ack;
  logic        fifo_full;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        mux_sel;
  logic        busy;

  tx_frame_arbiter #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ack  (req0_ack),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ack  (req1_ack),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .mux_sel   (mux_sel),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [15:0] d1;
    logic        full;
    logic        we;
    logic        chk_wd;
    logic [7:0]  wd;
    logic        a0;
    logic        a1;
    logic        mux;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [15:0] d1, input logic full,
                     input logic we, input logic chk_wd, input logic [7:0] wd,
                     input logic a0, input logic a1, input logic mux, input logic bsy);
    vec_t v;
    v = '{rst, v0, d0, v1, d1, full, we, chk_wd, wd, a0, a1, mux, bsy};
    vecs.push_back(v);
  endtask

  // Reference model: pending bytes of the frame in flight, a pending-ack flag
  // and the round-robin memory.
  logic [7:0] mq[$];
  logic       m_ackp;
  logic       m_grant;
  logic       m_last;

  task automatic model_reset();
    mq.delete();
    m_ackp  = 1'b0;
    m_grant = 1'b0;
    m_last  = 1'b1;
  endtask

  task automatic model_step(input logic rst, input logic v0, input logic [7:0] d0,
                            input logic v1, input logic [15:0] d1, input logic full);
    logic pick;
    if (rst) begin
      model_reset();
    end else if (mq.size() > 0) begin
      if (!full) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_ackp = 1'b1;
      end
    end else if (m_ackp) begin
      m_ackp = 1'b0;
    end else if (v0 || v1) begin
`ifdef TX_ARB_FIXED_PRIO_EN
      pick = v1;
`else
      pick = (v0 && v1) ? !m_last : v1;
`endif
      m_grant = pick;
      m_last  = pick;
      if (!pick) mq.push_back(d0);
      else begin
        mq.push_back(d1[7:0]);
        mq.push_back(d1[15:8]);
      end
    end
  endtask

  logic exp_order[4];
  int   nack;
  logic ea0, ea1, ew;

  initial begin
    RST = 1'b1; req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0; fifo_full = 1'b0;
    cyc(); cyc();
    RST = 1'b0;

    // ---- directed table ----
    add(0,0,8'h00,0,16'h0000,0, 0,1,8'h00,0,0,0,0);   // reset state
    add(0,1,8'hA5,0,16'h0000,0, 0,0,8'h00,0,0,0,0);   // req0 0xA5
    add(0,1,8'hA5,0,16'h0000,0, 1,1,8'hA5,0,0,0,1);
    add(0,1,8'hA5,0,16'h0000,0, 0,0,8'h00,1,0,0,1);
    add(0,0,8'h00,0,16'h0000,0, 0,0,8'h00,0,0,0,0);
    add(0,0,8'h00,1,16'h1234,0, 0,0,8'h00,0,0,0,0);   // req1 0x1234
    add(0,0,8'h00,1,16'h1234,0, 1,1,8'h34,0,0,1,1);
    add(0,0,8'h00,1,16'h1234,0, 1,1,8'h12,0,0,1,1);
    add(0,0,8'h00,1,16'h1234,0, 0,0,8'h00,0,1,1,1);
    add(0,0,8'h00,0,16'h0000,0, 0,0,8'h00,0,0,1,0);
    add(0,0,8'h00,1,16'hCAFE,0, 0,0,8'h00,0,0,1,0);   // req1 0xCAFE, stall
    add(0,0,8'h00,1,16'hCAFE,0, 1,1,8'hFE,0,0,1,1);
    add(0,0,8'h00,1,16'hCAFE,1, 0,1,8'hCA,0,0,1,1);
    add(0,0,8'h00,1,16'hCAFE,1, 0,1,8'hCA,0,0,1,1);
    add(0,0,8'h00,1,16'hCAFE,1, 0,1,8'hCA,0,0,1,1);
    add(0,0,8'h00,1,16'hCAFE,0, 1,1,8'hCA,0,0,1,1);
    add(0,0,8'h00,1,16'hCAFE,0, 0,0,8'h00,0,1,1,1);
    add(0,0,8'h00,0,16'h0000,0, 0,0,8'h00,0,0,1,0);
    add(0,1,8'h5A,0,16'h0000,0, 0,0,8'h00,0,0,1,0);   // capture at grant
    add(0,0,8'hFF,0,16'h0000,0, 1,1,8'h5A,0,0,0,1);
    add(0,0,8'hFF,0,16'h0000,0, 0,0,8'h00,1,0,0,1);
    add(0,0,8'h00,0,16'h0000,0, 0,0,8'h00,0,0,0,0);
    add(0,0,8'h00,1,16'hBEEF,0, 0,0,8'h00,0,0,0,0);   // reset in SEND1_HI
    add(0,0,8'h00,1,16'hBEEF,0, 1,1,8'hEF,0,0,1,1);
    add(1,0,8'h00,1,16'hBEEF,0, 1,1,8'hBE,0,0,1,1);
    add(0,0,8'h00,0,16'h0000,0, 0,1,8'h00,0,0,0,0);
    add(0,0,8'h00,0,16'h0000,0, 0,0,8'h00,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      RST = vecs[i].rst; req0_valid = vecs[i].v0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_data = vecs[i].d1; fifo_full = vecs[i].full;
      #1;
      chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].we);
      if (vecs[i].chk_wd) chk($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].wd);
      chk($sformatf("vec%0d_ack0", i), req0_ack, vecs[i].a0);
      chk($sformatf("vec%0d_ack1", i), req1_ack, vecs[i].a1);
      chk($sformatf("vec%0d_mux_sel", i), mux_sel, vecs[i].mux);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      cyc();
    end
    RST = 1'b0;

    // ---- both requesters continuously pending from reset ----
`ifdef TX_ARB_FIXED_PRIO_EN
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    RST = 1'b1; cyc(); RST = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 16'hBEEF;
    nack = 0;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      if (req0_ack || req1_ack) begin
        chk($sformatf("order%0d_grant", nack), req1_ack, exp_order[nack]);
        chk($sformatf("order%0d_mux_sel", nack), mux_sel, exp_order[nack]);
        nack++;
      end
      cyc();
    end
    chk("order_ack_count", nack, 4);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // ---- randomized run against the reference model ----
    RST = 1'b1; cyc(); cyc(); RST = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      RST       = ($urandom_range(0, 99) == 0);
      req0_data = 8'($urandom);
      req1_data = 16'($urandom);
      #1;
      ew  = (mq.size() > 0) && !fifo_full;
      ea0 = m_ackp && !m_grant;
      ea1 = m_ackp &&  m_grant;
      chk("rnd_wr_en", wr_en, ew);
      if (ew) chk("rnd_wr_data", wr_data, mq[0]);
      chk("rnd_ack0", req0_ack, ea0);
      chk("rnd_ack1", req1_ack, ea1);
      chk("rnd_mux_sel", mux_sel, m_grant);
      chk("rnd_busy", busy, (mq.size() > 0) || m_ackp);
      model_step(RST, req0_valid, req0_data, req1_valid, req1_data, fifo_full);
      cyc();
      if (req0_valid && ea0 && !RST) req0_valid = 1'b0;
      else if (!req0_valid) req0_valid = ($urandom_range(0, 2) == 0);
      if (req1_valid && ea1 && !RST) req1_valid = 1'b0;
      else if (!req1_valid) req1_valid = ($urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
